// File: rtl/microseq_param.sv
// microseq_param: parameterised microsequencer with conditional branch, opcode dispatch and return stack
module microseq_param #(
    parameter int AW          = 5,
    parameter int OPW         = 4,
    parameter int NFLAG       = 4,
    parameter int DEPTH       = 4,
    parameter int FETCH_ADDR  = 0,
    parameter int DISP_BASE   = 0,
    parameter int DISP_STRIDE = 2,
    localparam int CW  = (NFLAG > 1) ? $clog2(NFLAG) : 1,
    localparam int SPW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    na,
    input  logic [OPW-1:0]   opcode,
    input  logic [NFLAG-1:0] flags,
    input  logic [CW-1:0]    csel,
    input  logic             cinv,
    input  logic             hold,
    output logic [AW-1:0]    upc,
    output logic [SPW-1:0]   sp,
    output logic             stk_ovf,
    output logic             stk_unf
);
    typedef enum logic [2:0] {
        M_SEQ   = 3'd0,
        M_JUMP  = 3'd1,
        M_DISP  = 3'd2,
        M_CJMP  = 3'd3,
        M_CALL  = 3'd4,
        M_RET   = 3'd5,
        M_FETCH = 3'd6,
        M_SEQ7  = 3'd7
    } mode_t;

    logic [AW-1:0]     stk [DEPTH];
    logic [2**CW-1:0]  fext;
    logic              cond;
    logic [AW-1:0]     upc_inc;
    logic [AW-1:0]     disp;
    logic [AW-1:0]     top;
    logic [AW-1:0]     upc_n;
    logic [SPW-1:0]    sp_n;
    logic              ovf_n;
    logic              unf_n;
    logic              push;

    assign upc_inc = upc + AW'(1);
    assign disp    = AW'(DISP_BASE) + AW'(opcode) * AW'(DISP_STRIDE);
    assign cond    = fext[csel] ^ cinv;

    // Zero-extend the flags so out-of-range selects read as 0
    always_comb begin
        fext = '0;
        fext[NFLAG-1:0] = flags;
    end

    // Top-of-stack entry, only meaningful when sp > 0
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sp == SPW'(i + 1)) top = stk[i];
    end

    // Next-address selection and stack bookkeeping
    always_comb begin
        upc_n = upc_inc;
        sp_n  = sp;
        ovf_n = stk_ovf;
        unf_n = stk_unf;
        push  = 1'b0;
        case (mode_t'(mode))
            M_JUMP:  upc_n = na;
            M_DISP:  upc_n = disp;
            M_CJMP:  upc_n = cond ? na : upc_inc;
            M_CALL: begin
                upc_n = na;
                if (sp != SPW'(DEPTH)) begin
                    push = !hold;
                    sp_n = sp + SPW'(1);
                end else begin
                    ovf_n = 1'b1;
                end
            end
            M_RET: begin
                if (sp != '0) begin
                    upc_n = top;
                    sp_n  = sp - SPW'(1);
                end else begin
                    upc_n = AW'(FETCH_ADDR);
                    unf_n = 1'b1;
                end
            end
            M_FETCH: begin
                upc_n = AW'(FETCH_ADDR);
                sp_n  = '0;
            end
            default: upc_n = upc_inc;
        endcase
    end

    // Architectural state register, frozen while hold is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc     <= AW'(FETCH_ADDR);
            sp      <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (!hold) begin
            upc     <= upc_n;
            sp      <= sp_n;
            stk_ovf <= ovf_n;
            stk_unf <= unf_n;
        end
    end

    // Return-stack storage, written at the current occupancy on a push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++)
                if (sp == SPW'(i)) stk[i] <= upc_inc;
        end
    end
endmodule

// File: doc/microseq_param.md
MICROSEQ_PARAM -- requirements
Module: microseq_param

Interface
- REQ-001 Parameter AW, default 5: micro-address width.
- REQ-002 Parameter OPW, default 4: opcode field width.
- REQ-003 Parameter NFLAG, default 4: number of condition flags.
- REQ-004 Parameter DEPTH, default 4: micro-subroutine return-stack depth, DEPTH >= 1.
- REQ-005 Parameter FETCH_ADDR, default 0: fetch-entry micro-address.
- REQ-006 Parameters DISP_BASE, default 0, and DISP_STRIDE, default 2: dispatch address mapping.
- REQ-007 clk  input  1: single clock; all state updates on the rising edge.
- REQ-008 rst_n  input  1: asynchronous, active-low reset.
- REQ-009 mode  input  3: next-address select, encoding in REQ-015.
- REQ-010 na  input  AW: next/target micro-address from the microword.
- REQ-011 opcode  input  OPW: opcode field from the instruction register.
- REQ-012 flags  input  NFLAG: condition flags, for example Z; csel  input  max(1,$clog2(NFLAG)): flag select; cinv  input  1: invert the selected flag.
- REQ-013 hold  input  1: stall; when 1, all state SHALL be held.
- REQ-014 upc  output  AW: registered micro-PC; sp  output  $clog2(DEPTH+1): stack occupancy; stk_ovf and stk_unf  output  1 each: sticky stack-error flags.

Function
- REQ-015 When hold=0, the next upc SHALL be selected by mode:
  - 0 SEQ: upc+1.
  - 1 JUMP: na.
  - 2 DISPATCH: DISP_BASE + opcode*DISP_STRIDE.
  - 3 CJMP: na if cond=1, else upc+1.
  - 4 CALL: na.
  - 5 RET: the popped address.
  - 6 FETCH: FETCH_ADDR.
  - 7: same as SEQ.
- REQ-016 All address arithmetic SHALL be computed modulo 2^AW, so that upc+1 wraps from 2^AW-1 to 0.
- REQ-017 cond SHALL equal flags[csel] XOR cinv.
- REQ-018 If csel >= NFLAG, flags[csel] SHALL read as 0, giving cond = cinv.
- REQ-019 Flags and opcode SHALL be sampled only in the cycle whose mode uses them; other modes SHALL ignore them.
- REQ-020 Latency SHALL be one cycle: the inputs present at rising edge N determine upc after edge N, with no combinational path from inputs to upc.
- REQ-021 CALL with sp < DEPTH SHALL push upc+1 (modulo 2^AW) and increment sp.
- REQ-022 CALL with sp = DEPTH SHALL leave the stack and sp unchanged, set stk_ovf, and still jump to na.
- REQ-023 RET with sp > 0 SHALL load upc from the top of the stack and decrement sp.
- REQ-024 RET with sp = 0 SHALL load upc = FETCH_ADDR, set stk_unf, and leave sp at 0.
- REQ-025 FETCH SHALL set sp to 0, which empties the stack, and SHALL leave stk_ovf and stk_unf unchanged.
- REQ-026 stk_ovf and stk_unf SHALL remain set once set and SHALL be cleared only by reset.
- REQ-027 hold=1 SHALL freeze upc, sp, the stack contents and both error flags regardless of mode, including CALL and RET.
- REQ-028 Stack entries above sp are don't-care and SHALL never be observable on upc.

Reset
- REQ-029 rst_n=0 SHALL immediately, asynchronously, force upc=FETCH_ADDR, sp=0, stk_ovf=0 and stk_unf=0.
- REQ-030 While rst_n=0, state SHALL ignore clk and all other inputs.
- REQ-031 After rst_n is released, the first update SHALL occur on the next rising clk edge.
- REQ-032 Reset asserted mid-operation, including during CALL or RET, SHALL abort that operation with no partial stack update.

Verification (default parameters)
- REQ-033 Reset and dispatch: assert rst_n=0 mid-run -> upc=0, sp=0 and both error flags 0 without a clock edge. Then release, apply mode=1 with na=1, then mode=2 with opcode=11, then mode=0 -> upc=1, then 22, then 23.
- REQ-034 Conditional jump: set upc=5 with mode=3, csel=0, cinv=1, flags[0]=0, na=11 -> upc=11. Repeat from upc=5 with flags[0]=1 -> upc=6. Repeat with csel=3, flags=4'b0111, cinv=0 -> upc+1.
- REQ-035 Call and return: from upc=5, apply mode=4 with na=20 -> upc=20, sp=1. Then mode=5 -> upc=6, sp=0, no error flags set.
- REQ-036 Overflow and underflow: apply five CALLs with na=10,11,12,13,14 -> sp=4, stk_ovf=1 after the fifth, upc=14. Four RETs -> sp=0 and upc returns through the four pushed values. A fifth RET -> upc=0, stk_unf=1.
- REQ-037 Hold and wrap: hold=1 with mode=4 -> upc and sp unchanged. With DISP_BASE=4 and opcode=15, dispatch -> upc=2, since (4+30) mod 32 = 2. SEQ from upc=31 -> upc=0.
- REQ-038 Reset during CALL: assert rst_n=0 coincident with a CALL edge -> sp=0 and upc=0. Next FETCH with an empty stack keeps both error flags 0.
